// File: rtl/if_fetch.sv
// Instruction fetch unit: assembles a 32-bit little-endian instruction from four
// byte requests, presents it with its PC, and honours stall and redirect.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic [31:0] prediction_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] fpc_q, fpc_d;
  logic [23:0] buf_q, buf_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] inst_q, inst_d;
  logic        vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fpc_d   = fpc_q;
    buf_d   = buf_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    inst_d  = inst_q;
    vld_d   = vld_q;

    if (rst) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      fpc_d   = 32'h0;
      pc_d    = 32'h0;
      npc_d   = 32'h0;
      inst_d  = BUBBLE;
      vld_d   = 1'b0;
    end else if (jmp_i) begin
      // Redirect wins over stall and over a same-cycle grant; partial word dropped.
      state_d = FETCH;
      cnt_d   = 2'd0;
      fpc_d   = jmp_addr_i;
      inst_d  = BUBBLE;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
          cnt_d   = 2'd0;
        end
        FETCH: begin
          if (mem_gnt_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0: buf_d[7:0]   = mem_data_i;
              2'd1: buf_d[15:8]  = mem_data_i;
              2'd2: buf_d[23:16] = mem_data_i;
              default: begin
                state_d = DONE;
                inst_d  = {mem_data_i, buf_q};
                pc_d    = fpc_q;
                npc_d   = fpc_q + 32'd4;
                vld_d   = 1'b1;
              end
            endcase
          end
        end
        DONE: begin
          if (!stall_i) begin
            state_d = FETCH;
            cnt_d   = 2'd0;
            fpc_d   = fpc_q + 32'd4;
            inst_d  = BUBBLE;
            vld_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    fpc_q   <= fpc_d;
    buf_q   <= buf_d;
    pc_q    <= pc_d;
    npc_q   <= npc_d;
    inst_q  <= inst_d;
    vld_q   <= vld_d;
  end

  // Request is suppressed while reset is asserted so an aborted fetch issues nothing.
  assign mem_req_o    = (state_q == FETCH) && !rst;
  assign mem_addr_o   = fpc_q + {30'd0, cnt_q};
  assign pc_o         = pc_q;
  assign npc_o        = npc_q;
  assign prediction_o = npc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = vld_q;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 stall_i  input  1  downstream IF/ID cannot accept this cycle; holds the presented instruction.
REQ-004 jmp_i  input  1  redirect request from ID/EX (taken branch, JAL, JALR, mispredict).
REQ-005 jmp_addr_i  input  32  redirect target; used as-is, no alignment applied.
REQ-006 mem_req_o  output  1  byte fetch request to memory arbiter.
REQ-007 mem_addr_o  output  32  byte address of the current request.
REQ-008 mem_gnt_i  input  1  arbiter grant; mem_data_i is valid in the same cycle.
REQ-009 mem_data_i  input  8  fetched byte.
REQ-010 pc_o  output  32  address of the presented instruction.
REQ-011 npc_o  output  32  pc_o + 4, mod 2^32.
REQ-012 prediction_o  output  32  predicted next fetch address; static not-taken, equals npc_o.
REQ-013 inst_o  output  32  presented instruction; bubble 32'h00000000 when not valid.
REQ-014 inst_valid_o  output  1  inst_o holds a real fetched instruction.

Function
REQ-015 The bubble word SHALL be 32'h00000000; its opcode field equals the decoder's Flushed opcode 7'b0000000.
REQ-016 States: IDLE, FETCH, DONE; the internal byte counter cnt SHALL be 2 bits, and the internal fetch PC fpc SHALL be 32 bits.
REQ-017 IDLE: mem_req_o=0; next cycle SHALL be FETCH with cnt=0.
REQ-018 FETCH: mem_req_o=1, mem_addr_o=fpc+cnt; mem_req_o and mem_addr_o SHALL be held until mem_gnt_i.
REQ-019 On grant: mem_data_i SHALL be written to buffer byte cnt (byte 0 = bits 7:0, little-endian), and cnt SHALL increment.
REQ-020 The grant with cnt=3 SHALL transition to DONE.
REQ-021 Entering DONE: inst_o=assembled word, pc_o=fpc, npc_o=prediction_o=fpc+4, inst_valid_o=1, all from registers.
REQ-022 DONE, stall_i=0: the instruction is consumed that cycle; next cycle SHALL be FETCH with fpc=fpc+4 and cnt=0, inst_valid_o=0, inst_o=bubble.
REQ-023 DONE, stall_i=1: all outputs SHALL hold unchanged; mem_req_o=0.
REQ-024 Latency: with continuous grants, 4 request cycles SHALL be followed by 1 DONE cycle, i.e. 5 cycles per instruction.
REQ-025 Whenever inst_valid_o=0, inst_o SHALL be the bubble, and pc_o/npc_o SHALL hold their last values.
REQ-026 jmp_i=1 in any state SHALL, at the next edge, set fpc=jmp_addr_i, cnt=0, state=FETCH, inst_valid_o=0, inst_o=bubble.
REQ-027 jmp_i SHALL take priority over stall_i and over a same-cycle grant; the granted byte is discarded.
REQ-028 A partially assembled word SHALL never be presented after a redirect.
REQ-029 PC arithmetic SHALL wrap mod 2^32: fpc=32'hFFFFFFFC gives npc_o=32'h00000000; byte addresses wrap likewise.
REQ-030 mem_req_o SHALL be 0 in IDLE, in DONE, and in the reset cycle.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, fpc=0, cnt=0, pc_o=0, npc_o=0, prediction_o=0, inst_o=bubble, inst_valid_o=0, mem_req_o=0, mem_addr_o=0.
REQ-032 rst SHALL override jmp_i and stall_i; reset asserted mid-fetch SHALL abort the fetch, with no further request issued until after release.
REQ-033 The first request after release SHALL be mem_addr_o=0, two cycles after rst falls (one IDLE cycle, then FETCH).

Verification
REQ-034 Reset then continuous grant, bytes 13,00,10,00 -> mem_addr_o 0,1,2,3; then inst_o=32'h00100013, pc_o=0, npc_o=4, inst_valid_o=1 for one cycle; next request at addr 4.
REQ-035 Grant withheld 3 cycles on byte 1 -> mem_addr_o stays 1 and mem_req_o stays high; assembled word is correct; DONE arrives 3 cycles late.
REQ-036 stall_i=1 for 4 cycles in DONE -> outputs frozen, mem_req_o=0; fetch at pc+4 starts the cycle after stall_i drops.
REQ-037 jmp_i=1, jmp_addr_i=32'h00001000 during the byte-2 grant -> next mem_addr_o=32'h1000, inst_valid_o stays 0, and the first valid pc_o=32'h1000.
REQ-038 jmp_i together with stall_i in DONE -> instruction dropped, bubble output; fetch resumes at jmp_addr_i.
REQ-039 jmp_addr_i=32'hFFFFFFFC -> byte addresses FFFFFFFC..FFFFFFFF, npc_o=0; then rst mid-fetch -> mem_req_o=0 and all outputs at reset values next cycle.
